// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage
//
// Purpose:
//   Issues word-aligned reads to instruction memory, captures the returned
//   word into an instruction register and offers it to decode with a
//   valid/ready handshake. Redirects (br_valid/br_target) replace the PC at
//   any time. A read that is outstanding when a redirect arrives is allowed
//   to complete at its original address, and its data is thrown away.
//   One instruction is in flight at a time, so with a memory that acks the
//   cycle after the request, throughput is one instruction every three
//   cycles.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   PC_STEP     sequential PC increment in bytes
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   br_valid    redirect request (single-cycle qualifier)
//   br_target   redirect address, bits [1:0] are forced to zero
//   imem_req    instruction memory read request
//   imem_addr   read address (word aligned), stable until imem_ack
//   imem_ack    memory returns imem_rdata this cycle
//   imem_rdata  returned instruction word
//   inst_valid  instruction register holds a word for decode
//   inst_ready  decode accepts the word
//   inst_out    fetched instruction
//   inst_pc     address of inst_out
//   pc_next     inst_pc + PC_STEP (link / sequential value)
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_next
);

    // IDLE : one cycle after reset before the first request
    // FETCH: request outstanding at pc_q
    // KILL : request outstanding at kill_addr_q, its data will be dropped
    // HOLD : instruction register valid, waiting for decode
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_KILL  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] br_pc;

    // Redirect target with the byte offset cleared.
    assign br_pc = br_target & ~32'h3;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output is given a default before the case so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (br_valid && !imem_ack) begin
                    // Memory still owes us a word for the old address.
                    state_d = S_KILL;
                end else if (br_valid && imem_ack) begin
                    // Word arrived together with the redirect: drop it and
                    // start the redirected fetch right away.
                    state_d = S_FETCH;
                end else if (imem_ack) begin
                    state_d = S_HOLD;
                end
            end
            S_KILL: begin
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                // A redirect discards the held word even if decode takes it.
                if (br_valid || inst_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (decoded from the state register only)
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        inst_valid = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
            end
            S_KILL: begin
                // pc_q may already hold the redirect target; keep presenting
                // the address of the read that is still in flight.
                imem_req  = 1'b1;
                imem_addr = kill_addr_q;
            end
            S_HOLD: begin
                inst_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC and instruction register
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        inst_out_d  = inst_out_q;
        inst_pc_d   = inst_pc_q;
        case (state_q)
            S_FETCH: begin
                if (br_valid) begin
                    pc_d        = br_pc;
                    kill_addr_d = pc_q;
                end else if (imem_ack) begin
                    inst_out_d = imem_rdata;
                    inst_pc_d  = pc_q;
                    pc_d       = pc_q + PC_STEP;
                end
            end
            S_IDLE, S_KILL, S_HOLD: begin
                // A newer redirect always overwrites an older one.
                if (br_valid) begin
                    pc_d = br_pc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            inst_out_q  <= 32'h0;
            inst_pc_q   <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            inst_out_q  <= inst_out_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign inst_out = inst_out_q;
    assign inst_pc  = inst_pc_q;
    // Wraps modulo 2^32 by construction of the 32-bit add.
    assign pc_next  = inst_pc_q + PC_STEP;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 br_valid  input  1  redirect request, single-cycle qualifier.
REQ-006 br_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address, word aligned.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 inst_valid  output  1  instruction register holds a valid word for decode.
REQ-012 inst_ready  input  1  decode/reg_file stage accepts the word.
REQ-013 inst_out  output  32  fetched instruction.
REQ-014 inst_pc  output  32  address of inst_out.
REQ-015 pc_next  output  32  inst_pc + PC_STEP (link/sequential value), modulo 2^32.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, KILL, HOLD; encoding is free.
REQ-017 IDLE: imem_req=0, inst_valid=0; next state FETCH unconditionally, so the first request issues 1 cycle after rst deasserts.
REQ-018 FETCH: imem_req=1, imem_addr=PC; imem_addr SHALL be held stable until imem_ack.
REQ-019 FETCH with imem_ack and no br_valid: inst_out<=imem_rdata, inst_pc<=PC, PC<=PC+PC_STEP, inst_valid<=1, next state HOLD.
REQ-020 FETCH with br_valid and no imem_ack: PC<=br_target&~3, next state KILL; imem_req stays 1 with the old address.
REQ-021 FETCH with br_valid and imem_ack in the same cycle: imem_rdata discarded, PC<=br_target&~3, next state FETCH.
REQ-022 KILL: imem_req=1 at the old address; on imem_ack, data discarded and next state FETCH at the redirected PC; a further br_valid in KILL overwrites PC with the newer target.
REQ-023 HOLD: inst_valid=1; inst_out, inst_pc and pc_next SHALL remain stable while inst_ready=0.
REQ-024 HOLD with inst_valid&&inst_ready and no br_valid: inst_valid<=0, next state FETCH.
REQ-025 HOLD with br_valid, regardless of inst_ready: inst_valid<=0, PC<=br_target&~3, next state FETCH; redirect wins over handshake.
REQ-026 Latency: imem_ack to inst_valid is 1 cycle; inst handshake to next imem_req is 1 cycle; steady-state throughput is 1 instruction per 3 cycles with zero-wait memory.
REQ-027 PC arithmetic SHALL be 32-bit unsigned and wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 br_valid in IDLE SHALL load PC with the target; FETCH then issues at that target.
REQ-029 imem_ack outside FETCH/KILL SHALL be ignored.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, PC=RESET_PC, imem_req=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-031 pc_next SHALL read RESET_PC+PC_STEP... no: pc_next SHALL equal inst_pc+PC_STEP at all times, i.e. 32'h0000_0004 in reset.
REQ-032 rst asserted mid-FETCH or mid-KILL SHALL drop imem_req immediately; the pending transaction is abandoned and a later imem_ack is ignored per REQ-029.

Verification
REQ-033 Reset release, imem_ack one cycle after each req, inst_ready=1 -> imem_addr sequence 0x0,0x4,0x8; inst_pc matches; inst_valid pulses every 3rd cycle.
REQ-034 inst_ready held 0 for 5 cycles in HOLD with inst_out=0xE3A0_0001 -> outputs stable, imem_req=0 throughout; fetch of 0x4 starts 1 cycle after ready.
REQ-035 br_valid with br_target=0x103 during FETCH with ack delayed 3 cycles -> old address held, returned word never appears on inst_out, next imem_addr=0x100.
REQ-036 br_valid and imem_ack in the same cycle, target=0x200 -> inst_valid stays 0, next imem_addr=0x200.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first inst_pc=0xFFFF_FFFC, pc_next=0x0, second imem_addr=0x0.
REQ-038 rst pulsed mid-FETCH at addr 0x8 -> imem_req=0 in that cycle without clock edge; after release first imem_addr=RESET_PC.
